// File: rtl/apb_cmd_seq_if.sv
// -----------------------------------------------------------------------------
// apb_cmd_seq_if
//   Bundles the request/response handshake and the APB command bus of the
//   apb_cmd_seq sequencer.
//
//   Request side : req_valid/req_ready handshake with req_op, req_port,
//                  req_addr, req_wdata, req_mask.
//   Response side: rsp_valid one-cycle pulse with rsp_data, rsp_err,
//                  rsp_poll_fail.
//   APB side     : apb_cmd_en, apb_wr_en, apb_wr_addr, apb_wr_data, apb_port
//                  towards the APB controller; apb_done, apb_rd_data back.
//
//   slave  : the sequencer's view (accepts requests, drives the command bus).
//   master : the environment's view (requester plus APB controller).
// -----------------------------------------------------------------------------
interface apb_cmd_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic        req_port;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic [15:0] req_mask;

  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        rsp_poll_fail;

  logic        apb_wr_en;
  logic        apb_cmd_en;
  logic [7:0]  apb_wr_addr;
  logic [15:0] apb_wr_data;
  logic        apb_port;
  logic        apb_done;
  logic [15:0] apb_rd_data;

  modport slave (
    input  req_valid, req_op, req_port, req_addr, req_wdata, req_mask,
    input  apb_done, apb_rd_data,
    output req_ready, rsp_valid, rsp_data, rsp_err, rsp_poll_fail,
    output apb_wr_en, apb_cmd_en, apb_wr_addr, apb_wr_data, apb_port
  );

  modport master (
    output req_valid, req_op, req_port, req_addr, req_wdata, req_mask,
    output apb_done, apb_rd_data,
    input  req_ready, rsp_valid, rsp_data, rsp_err, rsp_poll_fail,
    input  apb_wr_en, apb_cmd_en, apb_wr_addr, apb_wr_data, apb_port
  );
endinterface

// File: rtl/apb_cmd_seq.sv
// -----------------------------------------------------------------------------
// apb_cmd_seq
//   Turns one high-level register request (write, read, read-modify-write or
//   poll) into a sequence of level-handshaked commands for an APB controller.
//
//   Each command: apb_cmd_en high for ISSUE_CYC cycles (ISSUE), then held
//   high until apb_done or TIMEOUT_CYC cycles (WAIT), then low for GAP_CYC
//   cycles (GAP). After the last command a one-cycle rsp_valid pulse (RESP)
//   reports the last read value, the timeout flag and the poll-exhausted flag.
//
//   Ports:
//     apb_clk   - clock, rising edge
//     apb_rst_n - asynchronous active-low reset
//     bus       - apb_cmd_seq_if.slave (request, response, APB command bus)
// -----------------------------------------------------------------------------
module apb_cmd_seq #(
  parameter int ISSUE_CYC   = 4,
  parameter int GAP_CYC     = 4,
  parameter int TIMEOUT_CYC = 1023,
  parameter int POLL_MAX    = 255
) (
  input  logic         apb_clk,
  input  logic         apb_rst_n,
  apb_cmd_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_GAP,
    S_RESP
  } state_e;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_RMW   = 2'b10,
    OP_POLL  = 2'b11
  } op_e;

  // One shared cycle counter serves ISSUE, WAIT and GAP; size it for the
  // longest of the three.
  localparam int CNT_MAX_IG = (ISSUE_CYC > GAP_CYC) ? ISSUE_CYC : GAP_CYC;
  localparam int CNT_MAX    = (TIMEOUT_CYC > CNT_MAX_IG) ? TIMEOUT_CYC : CNT_MAX_IG;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);
  localparam int POLL_W     = $clog2(POLL_MAX + 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [POLL_W-1:0]   poll_cnt_q, poll_cnt_d;
  op_e                 op_q, op_d;
  logic [15:0]         wdata_q, wdata_d;
  logic [15:0]         mask_q, mask_d;
  logic [15:0]         rd_q, rd_d;
  logic                more_q, more_d;       // another command follows the GAP
  logic                err_q, err_d;
  logic                poll_fail_q, poll_fail_d;
  logic                ready_q, ready_d;

  // Registered command bus.
  logic                cmd_en_q, cmd_en_d;
  logic                wr_en_q, wr_en_d;     // also marks the current phase
  logic [7:0]          addr_q, addr_d;
  logic [15:0]         wr_data_q, wr_data_d;
  logic                port_q, port_d;

  // Registered response.
  logic                rsp_valid_q, rsp_valid_d;
  logic [15:0]         rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;
  logic                rsp_poll_fail_q, rsp_poll_fail_d;

  logic [15:0]         rmw_data;
  logic                poll_hit;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: every flop, datapath included, has a reset value so that a reset
  // mid-operation drives the whole command bus and response to 0 at once.
  always_ff @(posedge apb_clk or negedge apb_rst_n) begin
    if (!apb_rst_n) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      poll_cnt_q      <= '0;
      op_q            <= OP_WRITE;
      wdata_q         <= '0;
      mask_q          <= '0;
      rd_q            <= '0;
      more_q          <= 1'b0;
      err_q           <= 1'b0;
      poll_fail_q     <= 1'b0;
      ready_q         <= 1'b0;
      cmd_en_q        <= 1'b0;
      wr_en_q         <= 1'b0;
      addr_q          <= '0;
      wr_data_q       <= '0;
      port_q          <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_data_q      <= '0;
      rsp_err_q       <= 1'b0;
      rsp_poll_fail_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values.
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      poll_cnt_q      <= poll_cnt_d;
      op_q            <= op_d;
      wdata_q         <= wdata_d;
      mask_q          <= mask_d;
      rd_q            <= rd_d;
      more_q          <= more_d;
      err_q           <= err_d;
      poll_fail_q     <= poll_fail_d;
      ready_q         <= ready_d;
      cmd_en_q        <= cmd_en_d;
      wr_en_q         <= wr_en_d;
      addr_q          <= addr_d;
      wr_data_q       <= wr_data_d;
      port_q          <= port_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_data_q      <= rsp_data_d;
      rsp_err_q       <= rsp_err_d;
      rsp_poll_fail_q <= rsp_poll_fail_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    state_d         = state_q;
    cnt_d           = cnt_q;
    poll_cnt_d      = poll_cnt_q;
    op_d            = op_q;
    wdata_d         = wdata_q;
    mask_d          = mask_q;
    rd_d            = rd_q;
    more_d          = more_q;
    err_d           = err_q;
    poll_fail_d     = poll_fail_q;
    wr_en_d         = wr_en_q;
    addr_d          = addr_q;
    wr_data_d       = wr_data_q;
    port_d          = port_q;
    rsp_valid_d     = 1'b0;
    rsp_data_d      = '0;
    rsp_err_d       = 1'b0;
    rsp_poll_fail_d = 1'b0;

    rmw_data = (bus.apb_rd_data & ~mask_q) | (wdata_q & mask_q);
    poll_hit = (bus.apb_rd_data & mask_q) == (wdata_q & mask_q);
    cnt_inc  = (cnt_q == CNT_W'(CNT_MAX)) ? cnt_q : cnt_q + CNT_W'(1);

    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid && ready_q) begin
          op_d        = op_e'(bus.req_op);
          wdata_d     = bus.req_wdata;
          mask_d      = bus.req_mask;
          addr_d      = bus.req_addr;
          port_d      = bus.req_port;
          wr_en_d     = (op_e'(bus.req_op) == OP_WRITE);
          wr_data_d   = (op_e'(bus.req_op) == OP_WRITE) ? bus.req_wdata : 16'h0000;
          rd_d        = '0;
          more_d      = 1'b0;
          err_d       = 1'b0;
          poll_fail_d = 1'b0;
          poll_cnt_d  = '0;
          cnt_d       = '0;
          state_d     = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (cnt_q == CNT_W'(ISSUE_CYC - 1)) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_WAIT: begin
        if (bus.apb_done) begin
          cnt_d   = '0;
          more_d  = 1'b0;
          state_d = S_GAP;
          if (!wr_en_q) begin
            rd_d = bus.apb_rd_data;
            unique case (op_q)
              OP_RMW: begin
                // Write phase of RMW reuses the address; the merged value is
                // only loaded on the bus once cmd_en has dropped.
                more_d    = 1'b1;
                wr_en_d   = 1'b1;
                wr_data_d = rmw_data;
              end
              OP_POLL: begin
                poll_cnt_d = (poll_cnt_q == POLL_W'(POLL_MAX)) ? poll_cnt_q
                                                               : poll_cnt_q + POLL_W'(1);
                if (!poll_hit) begin
                  if (poll_cnt_d == POLL_W'(POLL_MAX)) poll_fail_d = 1'b1;
                  else                                 more_d      = 1'b1;
                end
              end
              default: ;
            endcase
          end
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          // Timeout abandons any remaining phases.
          err_d   = 1'b1;
          more_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_GAP: begin
        if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
          cnt_d = '0;
          if (more_q) begin
            state_d = S_ISSUE;
          end else begin
            state_d         = S_RESP;
            rsp_valid_d     = 1'b1;
            rsp_data_d      = rd_q;
            rsp_err_d       = err_q;
            rsp_poll_fail_d = poll_fail_q;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    cmd_en_d = (state_d == S_ISSUE) || (state_d == S_WAIT);
    ready_d  = (state_d == S_IDLE);
  end

  assign bus.req_ready     = ready_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_data      = rsp_data_q;
  assign bus.rsp_err       = rsp_err_q;
  assign bus.rsp_poll_fail = rsp_poll_fail_q;
  assign bus.apb_cmd_en    = cmd_en_q;
  assign bus.apb_wr_en     = wr_en_q;
  assign bus.apb_wr_addr   = addr_q;
  assign bus.apb_wr_data   = wr_data_q;
  assign bus.apb_port      = port_q;

endmodule

// File: doc/apb_cmd_seq.md
APB_CMD_SEQ -- requirements
Module: apb_cmd_seq

Interface
REQ-001 SHALL have parameter ISSUE_CYC, default 4: cycles apb_cmd_en is held high before apb_done is monitored.
REQ-002 SHALL have parameter GAP_CYC, default 4: cycles apb_cmd_en is held low between consecutive APB commands.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1023: maximum WAIT cycles per APB command.
REQ-004 SHALL have parameter POLL_MAX, default 255: maximum reads per poll request.
REQ-005 SHALL have port apb_clk, input, 1: clock; all logic rising-edge.
REQ-006 SHALL have port apb_rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port req_valid, input, 1: request present.
REQ-008 SHALL have port req_ready, output, 1: high only in IDLE.
REQ-009 SHALL have port req_op, input, 2: operation code; 00 write, 01 read, 10 read-modify-write, 11 poll.
REQ-010 SHALL have port req_port, input, 1: target APB port (0/1).
REQ-011 SHALL have port req_addr, input, 8: register address.
REQ-012 SHALL have port req_wdata, input, 16: write value, or poll compare value.
REQ-013 SHALL have port req_mask, input, 16: RMW/poll bit mask.
REQ-014 SHALL have port rsp_valid, output, 1: one-cycle completion pulse.
REQ-015 SHALL have port rsp_data, output, 16: last read data (0 for write).
REQ-016 SHALL have port rsp_err, output, 1: timeout occurred; valid with rsp_valid.
REQ-017 SHALL have port rsp_poll_fail, output, 1: poll exhausted POLL_MAX; valid with rsp_valid.
REQ-018 SHALL have ports apb_wr_en (1), apb_cmd_en (1), apb_wr_addr (8), apb_wr_data (16), apb_port (1), all outputs and registered: command bus to the APB controller.
REQ-019 SHALL have ports apb_done (1) and apb_rd_data (16), both inputs: level-done status and read data from the APB controller.

Function
REQ-020 SHALL implement states IDLE, ISSUE, WAIT, GAP, RESP.
REQ-021 IDLE: on req_valid&req_ready SHALL capture all req_* fields and go to ISSUE; phase = write for op 00, read otherwise.
REQ-022 ISSUE: SHALL drive apb_cmd_en=1 with apb_wr_en/addr/data/port for the current phase, hold ISSUE_CYC cycles, then go to WAIT.
REQ-023 Command fields SHALL stay stable from the first ISSUE cycle through the last WAIT cycle.
REQ-024 WAIT: SHALL keep apb_cmd_en=1; on apb_done=1 SHALL capture apb_rd_data (read phases) and go to GAP.
REQ-025 WAIT: if TIMEOUT_CYC cycles elapse without apb_done, SHALL set the error flag, abandon remaining phases, and go to GAP.
REQ-026 GAP: SHALL drive apb_cmd_en=0 for GAP_CYC cycles, then go to ISSUE (next phase) or RESP.
REQ-027 RMW SHALL be read then write, with write data = (rd & ~req_mask) | (req_wdata & req_mask).
REQ-028 Poll SHALL repeat reads until (rd & req_mask) == (req_wdata & req_mask) or POLL_MAX reads are done; on exhaustion rsp_poll_fail=1.
REQ-029 RESP: SHALL pulse rsp_valid for exactly one cycle with rsp_data, rsp_err and rsp_poll_fail, then return to IDLE.
REQ-030 rsp_data SHALL be the last captured read (RMW: pre-modify value) and 0 for writes.
REQ-031 Poll and timeout counters SHALL saturate, never wrap, and clear on each request capture.
REQ-032 req_valid outside IDLE SHALL be ignored with no capture.

Reset
REQ-033 Asserting apb_rst_n low SHALL asynchronously force state IDLE, all outputs 0 (req_ready=1 after release), and all counters and flags 0, including mid-operation.
REQ-034 After reset release, the first ISSUE SHALL present a clean 0->1 edge on apb_cmd_en.

Verification
REQ-035 Write op=00 port=1 addr=0x12 wdata=0xA5A5, apb_done rising 3 cycles into WAIT -> apb_wr_en=1, apb_port=1, cmd_en high 4+3 cycles, rsp_valid 4 cycles later, rsp_data=0, rsp_err=0.
REQ-036 RMW addr=0x20 mask=0x00F0 wdata=0x0050 with rd=0x1234 -> second command writes 0x1254; rsp_data=0x1234.
REQ-037 Poll mask=0x0001 wdata=0x0001 with reads 0,0,1 -> exactly 3 read commands, rsp_poll_fail=0; with POLL_MAX=2 and all reads 0 -> 2 reads, rsp_poll_fail=1.
REQ-038 Read with apb_done held 0 -> rsp_err=1 after exactly 1023 WAIT cycles, cmd_en low for 4 GAP cycles, then rsp_valid.
REQ-039 apb_rst_n asserted during WAIT of an RMW -> all outputs 0 immediately; next request executes normally from ISSUE.
REQ-040 req_valid held high during RESP and across back-to-back requests -> one capture per IDLE visit, and apb_cmd_en low ≥4 cycles between commands.
